// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_sweeper
// Purpose  : Programmable N-input truth table that sweeps every input vector
//            into an external gate-level device, records mismatches per
//            vector, and offers a registered live-evaluation lookup.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
  parameter int                      N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0]    TT_INIT = 8'hB2,
  parameter int                      SETTLE  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tt_load_valid,
  input  logic [(1<<N_IN)-1:0]  tt_load_data,
  output logic                  tt_load_ready,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [N_IN-1:0]       in_vec,
  input  logic                  dut_out,
  output logic [(1<<N_IN)-1:0]  mismatch_map,
  output logic [N_IN:0]         mismatch_count,
  output logic                  pass,
  input  logic [N_IN-1:0]       eval_in,
  output logic                  eval_out
);

  localparam int c_nv = 1 << N_IN;
  localparam int c_hw = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [c_hw-1:0] c_settle = c_hw'(SETTLE);
  localparam logic [N_IN-1:0] c_last   = {N_IN{1'b1}};

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_drive  = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [c_nv-1:0] r_tt;
  logic [c_nv-1:0] w_tt_rev;
  logic [c_hw-1:0] r_hold;
  logic [N_IN-1:0] r_in_vec;
  logic [c_nv-1:0] r_map;
  logic [N_IN:0]   r_count;
  logic [N_IN:0]   w_count_next;
  logic            r_pass;
  logic            r_eval;
  logic            w_miss;
  logic            w_last;

  // The table is stored MSB-first; reversing it lets vector idx index bit idx.
  for (genvar gi = 0; gi < c_nv; gi++) begin : g_rev
    assign w_tt_rev[gi] = r_tt[c_nv-1-gi];
  end

  assign w_miss       = dut_out ^ w_tt_rev[r_in_vec];
  assign w_last       = (r_in_vec == c_last);
  assign w_count_next = r_count + {{N_IN{1'b0}}, w_miss};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        // A simultaneous load takes priority and suppresses the start.
        if (start && !tt_load_valid) begin
          w_next_state = c_st_drive;
        end
      end
      c_st_drive: begin
        if (r_hold == '0) begin
          w_next_state = c_st_sample;
        end
      end
      c_st_sample: begin
        w_next_state = w_last ? c_st_done : c_st_drive;
      end
      c_st_done: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  always_comb begin
    tt_load_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      c_st_idle:   tt_load_ready = 1'b1;
      c_st_drive:  busy          = 1'b1;
      c_st_sample: busy          = 1'b1;
      c_st_done:   done          = 1'b1;
      default: begin
        tt_load_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt     <= TT_INIT;
      r_hold   <= '0;
      r_in_vec <= '0;
      r_map    <= '0;
      r_count  <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (tt_load_valid) begin
            r_tt <= tt_load_data;
          end else if (start) begin
            r_map    <= '0;
            r_count  <= '0;
            r_pass   <= 1'b0;
            r_in_vec <= '0;
            r_hold   <= c_settle;
          end
        end
        c_st_drive: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - 1'b1;
          end
        end
        c_st_sample: begin
          if (w_miss) begin
            r_map[r_in_vec] <= 1'b1;
          end
          r_count <= w_count_next;
          // Pass is resolved with the last vector folded in so it is valid alongside done.
          if (w_last) begin
            r_pass <= (w_count_next == '0);
          end else begin
            r_in_vec <= r_in_vec + 1'b1;
            r_hold   <= c_settle;
          end
        end
        default: begin
          r_hold <= r_hold;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eval <= 1'b0;
    end else begin
      r_eval <= w_tt_rev[eval_in];
    end
  end

  assign in_vec         = r_in_vec;
  assign mismatch_map   = r_map;
  assign mismatch_count = r_count;
  assign pass           = r_pass;
  assign eval_out       = r_eval;

endmodule
`default_nettype wire
